// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squash,
// cache-miss freezes, HALT retirement, plus a stall counter and miss-timeout flag.
//
// state   | meaning
// RUN     | normal flow; hazards resolved by bubbles/flushes this cycle
// WAIT_D  | frozen, waiting for D-cache fill
// WAIT_I  | frozen, waiting for I-cache fill
// WAIT_DI | frozen, waiting for both fills
// HALT    | HALT retired; everything held until rst
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       read_reg1_IF_ID,
  input  logic [2:0]       read_reg2_IF_ID,
  input  logic             rd1_used,
  input  logic             rd2_used,
  input  logic [2:0]       w1_reg_ID_EX,
  input  logic             reg_en_ID_EX,
  input  logic             mem_rd_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             mem_en_EX_MEM,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  input  logic             imem_stall,
  input  logic             imem_done,
  input  logic             halt_MEM_WB,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIM = WCNT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    ST_RUN, ST_WAIT_D, ST_WAIT_I, ST_WAIT_DI, ST_HALT
  } state_t;

  state_t             state_q, state_d;
  logic               halted_q, halted_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic load_use, d_miss, i_miss, d_pend, i_pend, d_left, i_left, waiting;

  assign load_use = mem_rd_ID_EX & reg_en_ID_EX &
                    ((rd1_used & (w1_reg_ID_EX == read_reg1_IF_ID)) |
                     (rd2_used & (w1_reg_ID_EX == read_reg2_IF_ID)));
  assign d_miss   = dmem_stall & mem_en_EX_MEM;
  assign i_miss   = imem_stall;
  assign d_pend   = (state_q == ST_WAIT_D) || (state_q == ST_WAIT_DI);
  assign i_pend   = (state_q == ST_WAIT_I) || (state_q == ST_WAIT_DI);
  assign d_left   = d_pend & ~dmem_done;
  assign i_left   = i_pend & ~imem_done;
  assign waiting  = d_pend | i_pend;

  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (halt_MEM_WB) begin
          state_d = ST_HALT;
        end else if (d_miss | i_miss) begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_en    = 1'b0;
          mem_wb_flush = 1'b1;
          if (d_miss && i_miss) state_d = ST_WAIT_DI;
          else if (d_miss)      state_d = ST_WAIT_D;
          else                  state_d = ST_WAIT_I;
        end else if (branch_taken_EX) begin
          // squashing ID makes any load-use against it moot
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      ST_WAIT_D, ST_WAIT_I, ST_WAIT_DI: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
        if (d_left && i_left) state_d = ST_WAIT_DI;
        else if (d_left)      state_d = ST_WAIT_D;
        else if (i_left)      state_d = ST_WAIT_I;
        else                  state_d = ST_RUN;
      end
      ST_HALT: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
    end
  end

  always_comb begin
    halted_d      = halted_q | (state_d == ST_HALT);
    stall_count_d = stall_count_q;
    if (!pc_en && (state_q != ST_HALT) && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
    // wait counter parks at the limit so a long miss cannot wrap it
    wait_cnt_d = '0;
    if (waiting)
      wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + WCNT_W'(1);
    mem_timeout_d = mem_timeout_q | (waiting && (wait_cnt_d == WAIT_LIM));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      halted_q      <= halted_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_count_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for single-cycle RUN hazards,
// hand sequences for misses, overlap, timeout and HALT.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] GO  = 8'b11111_000;
  localparam logic [7:0] LU  = 8'b00111_010;
  localparam logic [7:0] BR  = 8'b11111_110;
  localparam logic [7:0] FRZ = 8'b00001_001;
  localparam logic [7:0] OFF = 8'b00000_000;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] read_reg1_IF_ID, read_reg2_IF_ID, w1_reg_ID_EX;
  logic rd1_used, rd2_used, reg_en_ID_EX, mem_rd_ID_EX, branch_taken_EX, mem_en_EX_MEM;
  logic dmem_stall, dmem_done, imem_stall, imem_done, halt_MEM_WB;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush, halted, mem_timeout;
  logic [15:0] stall_count;
  logic [7:0] ctl;

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, mem_wb_flush};

  pipe_hazard_ctrl #(.CNT_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .read_reg1_IF_ID(read_reg1_IF_ID), .read_reg2_IF_ID(read_reg2_IF_ID),
    .rd1_used(rd1_used), .rd2_used(rd2_used), .w1_reg_ID_EX(w1_reg_ID_EX),
    .reg_en_ID_EX(reg_en_ID_EX), .mem_rd_ID_EX(mem_rd_ID_EX),
    .branch_taken_EX(branch_taken_EX), .mem_en_EX_MEM(mem_en_EX_MEM),
    .dmem_stall(dmem_stall), .dmem_done(dmem_done),
    .imem_stall(imem_stall), .imem_done(imem_done), .halt_MEM_WB(halt_MEM_WB),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0] rr1, rr2;
    logic       rd1u, rd2u;
    logic [2:0] w1;
    logic       reg_en, mem_rd, br, mem_en, dst;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_reg1_IF_ID = '0; read_reg2_IF_ID = '0; w1_reg_ID_EX = '0;
    rd1_used = 0; rd2_used = 0; reg_en_ID_EX = 0; mem_rd_ID_EX = 0;
    branch_taken_EX = 0; mem_en_EX_MEM = 0; dmem_stall = 0; dmem_done = 0;
    imem_stall = 0; imem_done = 0; halt_MEM_WB = 0;
  endtask

  // leaves the bench at the start of the first cycle after rst falls, already checked
  task automatic do_reset(input string tag);
    idle();
    rst = 1;
    branch_taken_EX = 1;
    tick();
    @(negedge clk);
    chk({tag, "_rst_ctl"}, 32'(ctl), 32'(OFF));
    tick();
    rst = 0;
    branch_taken_EX = 0;
    @(negedge clk);
    chk({tag, "_post_rst"}, {29'd0, halted, mem_timeout, |stall_count}, 32'd0);
    chk({tag, "_post_rst_ctl"}, 32'(ctl), 32'(GO));
    tick();
  endtask

  int exp_cnt;

  initial begin
    vecs[0]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU};
    vecs[1]  = '{3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GO};
    vecs[2]  = '{3'd5, 3'd3, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU};
    vecs[3]  = '{3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, GO};
    vecs[4]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, GO};
    vecs[5]  = '{3'd3, 3'd2, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, GO};
    vecs[6]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BR};
    vecs[7]  = '{3'd1, 3'd2, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR};
    vecs[8]  = '{3'd0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU};
    vecs[9]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, GO};
    vecs[10] = '{3'd7, 3'd7, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LU};
    vecs[11] = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, GO};

    idle();
    rst = 1;
    tick();

    // single-cycle hazards in RUN
    do_reset("tbl");
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      read_reg1_IF_ID = vecs[i].rr1; read_reg2_IF_ID = vecs[i].rr2;
      rd1_used = vecs[i].rd1u; rd2_used = vecs[i].rd2u;
      w1_reg_ID_EX = vecs[i].w1; reg_en_ID_EX = vecs[i].reg_en;
      mem_rd_ID_EX = vecs[i].mem_rd; branch_taken_EX = vecs[i].br;
      mem_en_EX_MEM = vecs[i].mem_en; dmem_stall = vecs[i].dst;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_cnt", i), 32'(stall_count), 32'(exp_cnt));
      if (!vecs[i].exp[7]) exp_cnt++;
      tick();
    end
    idle();
    @(negedge clk);
    chk("tbl_final_cnt", 32'(stall_count), 32'(exp_cnt));
    tick();

    // D-miss: 5 stall cycles, done on the 6th, RUN on the 7th
    do_reset("dmiss");
    for (int c = 0; c < 7; c++) begin
      idle();
      mem_en_EX_MEM = (c == 0);
      dmem_stall = (c <= 5);
      dmem_done = (c == 5);
      @(negedge clk);
      chk($sformatf("dmiss_c%0d_ctl", c), 32'(ctl), 32'((c <= 5) ? FRZ : GO));
      tick();
    end
    idle();
    @(negedge clk);
    chk("dmiss_cnt", 32'(stall_count), 32'd6);
    tick();

    // overlapping misses: imem_done 3 cycles ahead of dmem_done
    do_reset("ovl");
    for (int c = 0; c < 7; c++) begin
      idle();
      mem_en_EX_MEM = (c == 0);
      dmem_stall = (c <= 5);
      imem_stall = (c <= 1) || (c == 3) || (c == 4);
      imem_done = (c == 2);
      dmem_done = (c == 5);
      @(negedge clk);
      chk($sformatf("ovl_c%0d_ctl", c), 32'(ctl), 32'((c <= 5) ? FRZ : GO));
      tick();
    end
    idle();
    @(negedge clk);
    chk("ovl_cnt", 32'(stall_count), 32'd6);
    tick();

    // timeout with MAX_WAIT = 4
    do_reset("tmo");
    for (int c = 0; c < 12; c++) begin
      idle();
      mem_en_EX_MEM = (c == 0);
      dmem_stall = (c <= 10);
      dmem_done = (c == 10);
      @(negedge clk);
      chk($sformatf("tmo_c%0d_flag", c), {31'd0, mem_timeout}, {31'd0, (c >= 5)});
      chk($sformatf("tmo_c%0d_ctl", c), 32'(ctl), 32'((c <= 10) ? FRZ : GO));
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("tmo_cleared", {31'd0, mem_timeout}, 32'd0);
    tick();

    // HALT, then a one-cycle reset in the middle of it
    do_reset("halt");
    read_reg1_IF_ID = 3'd2; rd1_used = 1; w1_reg_ID_EX = 3'd2;
    reg_en_ID_EX = 1; mem_rd_ID_EX = 1;
    @(negedge clk);
    chk("halt_pre_lu", 32'(ctl), 32'(LU));
    tick();
    idle();
    halt_MEM_WB = 1;
    @(negedge clk);
    chk("halt_retire_ctl", 32'(ctl), 32'(GO));
    chk("halt_retire_flag", {31'd0, halted}, 32'd0);
    tick();
    for (int c = 0; c < 4; c++) begin
      idle();
      dmem_stall = 1; mem_en_EX_MEM = 1; imem_stall = (c == 2);
      @(negedge clk);
      chk($sformatf("halt_c%0d_ctl", c), 32'(ctl), 32'(OFF));
      chk($sformatf("halt_c%0d_flag", c), {31'd0, halted}, 32'd1);
      chk($sformatf("halt_c%0d_cnt", c), 32'(stall_count), 32'd1);
      tick();
    end
    idle();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chk("halt_rst_flag", {31'd0, halted}, 32'd0);
    chk("halt_rst_cnt", 32'(stall_count), 32'd0);
    chk("halt_rst_ctl", 32'(ctl), 32'(GO));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
